count_round_ctrl: RTL and testbench

Parametrised round controller for the counting game. It plays `ROUNDS` rounds against a player who sets a `DATA_W`-bit guess on switches and presses start. Each round has a tick-based countdown, and the block keeps hit/miss scoring, an end-of-game state and a beep request. It sits between the switch/button inputs and the display drivers (seg/dig/matrix/led) in the game top, and replaces the fixed 7-bit, fixed-round game core.

---
 rtl/count_round_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_count_round_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_round_ctrl.sv
// count_round_ctrl: round controller for the counting game.
//
// The game runs ROUNDS rounds. In each round the player sets a DATA_W-bit guess and presses
// start before a tick-based countdown expires. The block keeps hit/miss scoring, an
// end-of-game state and a buzzer request.
//
// Ports:
//   clk_i        system clock, single domain
//   rst_ni       asynchronous active-low reset
//   en_i         game enable (power switch); low forces IDLE
//   start_i      push-button level; only rising edges are events
//   guess_i      player answer
//   target_o     current round target
//   round_idx_o  rounds started, 0..ROUNDS
//   score_o      hits so far
//   time_left_o  remaining countdown ticks
//   state_o      FSM state: IDLE=0 LOAD=1 RUN=2 JUDGE=3 WAIT=4 DONE=5
//   hit_o        one-cycle pulse on a correct answer
//   miss_o       one-cycle pulse on a wrong answer or timeout
//   done_o       high in DONE
//   beep_o       buzzer request
module count_round_ctrl #(
    parameter int unsigned DATA_W      = 7,
    parameter int unsigned ROUNDS      = 3,
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned ROUND_TICKS = 100,
    parameter int unsigned SEED        = 32'h2B,
    parameter int unsigned BEEP_CYC    = 1000
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic                             start_i,
    input  logic [DATA_W-1:0]                guess_i,
    output logic [DATA_W-1:0]                target_o,
    output logic [$clog2(ROUNDS+1)-1:0]      round_idx_o,
    output logic [$clog2(ROUNDS+1)-1:0]      score_o,
    output logic [$clog2(ROUND_TICKS+1)-1:0] time_left_o,
    output logic [2:0]                       state_o,
    output logic                             hit_o,
    output logic                             miss_o,
    output logic                             done_o,
    output logic                             beep_o
);

    localparam int unsigned RW = $clog2(ROUNDS + 1);
    localparam int unsigned TW = $clog2(ROUND_TICKS + 1);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = (BEEP_CYC > 0) ? $clog2(BEEP_CYC + 1) : 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRun   = 3'd2,
        StJudge = 3'd3,
        StWait  = 3'd4,
        StDone  = 3'd5
    } state_e;

    state_e            state_q;
    logic              start_q;
    logic [DATA_W-1:0] src_q;
    logic [DATA_W-1:0] target_q;
    logic [RW-1:0]     round_idx_q;
    logic [RW-1:0]     score_q;
    logic [TW-1:0]     time_left_q;
    logic [PW-1:0]     presc_q;
    logic              answered_q;  // JUDGE entered by a press rather than a timeout
    logic              ans_ok_q;    // guess matched target at the press
    logic              hit_q;
    logic              miss_q;
    logic [BW-1:0]     beep_cnt_q;

    logic srise;
    logic wrap;

    assign srise = start_i & ~start_q;
    assign wrap  = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            src_q       <= DATA_W'(SEED);
            target_q    <= '0;
            round_idx_q <= '0;
            score_q     <= '0;
            time_left_q <= '0;
            presc_q     <= '0;
            answered_q  <= 1'b0;
            ans_ok_q    <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            beep_cnt_q  <= '0;
        end else begin
            start_q <= start_i;
            // Free-running target source; keeps counting even while disabled.
            src_q   <= src_q + DATA_W'(1);
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            if (beep_cnt_q != '0) begin
                beep_cnt_q <= beep_cnt_q - BW'(1);
            end

            if (!en_i) begin
                state_q     <= StIdle;
                target_q    <= '0;
                round_idx_q <= '0;
                score_q     <= '0;
                time_left_q <= '0;
                presc_q     <= '0;
                beep_cnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (srise) begin
                            state_q <= StLoad;
                        end
                    end
                    StLoad: begin
                        target_q    <= src_q;
                        time_left_q <= TW'(ROUND_TICKS);
                        round_idx_q <= round_idx_q + RW'(1);
                        presc_q     <= '0;
                        state_q     <= StRun;
                    end
                    StRun: begin
                        if (wrap) begin
                            presc_q     <= '0;
                            time_left_q <= time_left_q - TW'(1);
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                        // A press on the final wrap edge still counts as an answer.
                        if (srise) begin
                            answered_q <= 1'b1;
                            ans_ok_q   <= (guess_i == target_q);
                            state_q    <= StJudge;
                        end else if (wrap && time_left_q == TW'(1)) begin
                            answered_q <= 1'b0;
                            ans_ok_q   <= 1'b0;
                            state_q    <= StJudge;
                        end
                    end
                    StJudge: begin
                        if (answered_q && ans_ok_q) begin
                            hit_q      <= 1'b1;
                            score_q    <= score_q + RW'(1);
                            beep_cnt_q <= BW'(BEEP_CYC);
                        end else begin
                            miss_q <= 1'b1;
                        end
                        state_q <= (round_idx_q == RW'(ROUNDS)) ? StDone : StWait;
                    end
                    StWait: begin
                        if (srise) begin
                            state_q <= StLoad;
                        end
                    end
                    StDone: begin
                        if (srise) begin
                            state_q     <= StIdle;
                            target_q    <= '0;
                            round_idx_q <= '0;
                            score_q     <= '0;
                            time_left_q <= '0;
                            beep_cnt_q  <= '0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign target_o    = target_q;
    assign round_idx_o = round_idx_q;
    assign score_o     = score_q;
    assign time_left_o = time_left_q;
    assign state_o     = state_q;
    assign hit_o       = hit_q;
    assign miss_o      = miss_q;
    assign done_o      = (state_q == StDone);
    // A perfect game holds the buzzer on for as long as DONE lasts.
    assign beep_o      = (beep_cnt_q != '0) || (state_q == StDone && score_q == RW'(ROUNDS));

endmodule

// File: tb/tb_count_round_ctrl.sv
// Self-checking bench for count_round_ctrl with small timing parameters.
module tb_count_round_ctrl;

    localparam int SEEDV = 'h2B;
    localparam int NR    = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       start = 1'b0;
    logic [6:0] guess = '0;
    logic [6:0] target;
    logic [1:0] round_idx;
    logic [1:0] score;
    logic [2:0] time_left;
    logic [2:0] state;
    logic       hit, miss, done, beep;

    count_round_ctrl #(
        .DATA_W     (7),
        .ROUNDS     (3),
        .TICK_DIV   (4),
        .ROUND_TICKS(5),
        .SEED       (32'h2B),
        .BEEP_CYC   (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .start_i    (start),
        .guess_i    (guess),
        .target_o   (target),
        .round_idx_o(round_idx),
        .score_o    (score),
        .time_left_o(time_left),
        .state_o    (state),
        .hit_o      (hit),
        .miss_o     (miss),
        .done_o     (done),
        .beep_o     (beep)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release: the target source equals SEED plus this count.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;
    int exp_score = 0;
    int exp_round = 0;
    logic [6:0] exp_tgt;

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Idle cycle, press, then LOAD and RUN; returns in the first RUN cycle.
    task automatic begin_round();
        step();
        press();
        step();
        exp_tgt = 7'((SEEDV + cyc - 1) % 128);
        exp_round++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", state);
        end
        checks++;
        if ({target, round_idx, score, time_left} !== '0) begin
            errors++; $display("FAIL reset_counters: tgt=%0d rnd=%0d sc=%0d tl=%0d want all 0",
                               target, round_idx, score, time_left);
        end
        checks++;
        if ({hit, miss, done, beep} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {hit, miss, done, beep});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_held_start();
        int loads = 0;
        int tl_first = -1;
        en = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state == 3'd1) begin
                loads++;
                exp_tgt = 7'((SEEDV + cyc) % 128);
            end
            if (state == 3'd2 && tl_first < 0) tl_first = int'(time_left);
        end
        start = 1'b0;
        exp_round = 1;
        exp_score = 0;
        checks++;
        if (loads != 1) begin
            errors++; $display("FAIL held_start_loads: got %0d want 1", loads);
        end
        checks++;
        if (state !== 3'd2 || round_idx !== 2'd1) begin
            errors++; $display("FAIL held_start_run: state=%0d rnd=%0d want 2/1", state, round_idx);
        end
        checks++;
        if (tl_first != 5) begin
            errors++; $display("FAIL held_start_time: got %0d want 5", tl_first);
        end
        checks++;
        if (target !== exp_tgt) begin
            errors++; $display("FAIL held_start_target: got %0h want %0h", target, exp_tgt);
        end
    endtask

    task automatic test_hits();
        int bcnt;
        for (int r = 1; r <= NR; r++) begin
            if (r > 1) begin
                begin_round();
                checks++;
                if (state !== 3'd2 || round_idx !== 2'(exp_round) || target !== exp_tgt
                    || time_left !== 3'd5) begin
                    errors++; $display("FAIL hit_load: st=%0d rnd=%0d tgt=%0h tl=%0d want 2/%0d/%0h/5",
                                       state, round_idx, target, time_left, exp_round, exp_tgt);
                end
                step($urandom_range(0, 10));
            end else begin
                step($urandom_range(1, 5));
            end
            guess = exp_tgt;
            press();
            checks++;
            if (state !== 3'd3) begin
                errors++; $display("FAIL hit_judge_state: got %0d want 3", state);
            end
            step();
            exp_score++;
            checks++;
            if (hit !== 1'b1 || miss !== 1'b0 || score !== 2'(exp_score)) begin
                errors++; $display("FAIL hit_pulse: hit=%b miss=%b score=%0d want 1/0/%0d",
                                   hit, miss, score, exp_score);
            end
            bcnt = int'(beep);
            step();
            checks++;
            if (hit !== 1'b0) begin
                errors++; $display("FAIL hit_single: got %b want 0", hit);
            end
            bcnt += int'(beep);
            for (int k = 0; k < 19; k++) begin
                step();
                bcnt += int'(beep);
            end
            checks++;
            if (bcnt != ((r == NR) ? 21 : 8)) begin
                errors++; $display("FAIL hit_beep_len: got %0d want %0d", bcnt, (r == NR) ? 21 : 8);
            end
        end
        checks++;
        if (done !== 1'b1 || state !== 3'd5 || score !== 2'd3 || beep !== 1'b1) begin
            errors++; $display("FAIL hit_done: done=%b st=%0d sc=%0d beep=%b want 1/5/3/1",
                               done, state, score, beep);
        end
        press();
        exp_round = 0;
        exp_score = 0;
        checks++;
        if (state !== 3'd0 || {target, round_idx, score, time_left} !== '0
            || {done, beep} !== 2'b0) begin
            errors++; $display("FAIL hit_clear: st=%0d sc=%0d rnd=%0d done=%b beep=%b want 0",
                               state, score, round_idx, done, beep);
        end
    endtask

    task automatic test_misses();
        for (int r = 1; r <= NR; r++) begin
            begin_round();
            step($urandom_range(0, 10));
            guess = exp_tgt ^ 7'd1;
            press();
            step();
            checks++;
            if (miss !== 1'b1 || hit !== 1'b0 || score !== 2'd0) begin
                errors++; $display("FAIL miss_pulse: miss=%b hit=%b score=%0d want 1/0/0",
                                   miss, hit, score);
            end
        end
        checks++;
        if (done !== 1'b1 || score !== 2'd0 || beep !== 1'b0) begin
            errors++; $display("FAIL miss_done: done=%b sc=%0d beep=%b want 1/0/0", done, score, beep);
        end
        step();
        press();
        exp_round = 0;
    endtask

    task automatic test_random_rounds();
        logic exp_hit;
        exp_score = 0;
        for (int r = 1; r <= NR; r++) begin
            begin_round();
            step($urandom_range(0, 15));
            guess = ($urandom_range(0, 1) == 1) ? exp_tgt : 7'($urandom);
            exp_hit = (guess == exp_tgt);
            if (exp_hit) exp_score++;
            press();
            step();
            checks++;
            if (hit !== exp_hit || miss !== !exp_hit || score !== 2'(exp_score)) begin
                errors++; $display("FAIL rand_round: hit=%b miss=%b sc=%0d want %b/%b/%0d",
                                   hit, miss, score, exp_hit, !exp_hit, exp_score);
            end
        end
        step(10);
        checks++;
        if (done !== 1'b1 || beep !== (exp_score == NR)) begin
            errors++; $display("FAIL rand_done: done=%b beep=%b want 1/%b", done, beep, exp_score == NR);
        end
        press();
        exp_round = 0;
        exp_score = 0;
    endtask

    task automatic test_timeout();
        int bad = 0;
        begin_round();
        for (int i = 0; i < 20; i++) begin
            if (state !== 3'd2 || time_left !== 3'(5 - i / 4)) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL timeout_steps: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (state !== 3'd3 || time_left !== 3'd0) begin
            errors++; $display("FAIL timeout_judge: st=%0d tl=%0d want 3/0", state, time_left);
        end
        step();
        checks++;
        if (miss !== 1'b1 || hit !== 1'b0 || state !== 3'd4) begin
            errors++; $display("FAIL timeout_miss: miss=%b hit=%b st=%0d want 1/0/4", miss, hit, state);
        end
    endtask

    task automatic test_coincident();
        begin_round();
        step(19);
        guess = exp_tgt;
        press();
        checks++;
        if (state !== 3'd3 || time_left !== 3'd0) begin
            errors++; $display("FAIL coinc_judge: st=%0d tl=%0d want 3/0", state, time_left);
        end
        step();
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0 || score !== 2'd1) begin
            errors++; $display("FAIL coinc_hit: hit=%b miss=%b sc=%0d want 1/0/1", hit, miss, score);
        end
    endtask

    task automatic test_en_low();
        en = 1'b0;
        step();
        en = 1'b1;
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL en_idle: got %0d want 0", state);
        end
        exp_round = 0;
        begin_round();
        guess = exp_tgt;
        press();
        step();
        begin_round();
        step(3);
        en = 1'b0;
        step();
        checks++;
        if (state !== 3'd0 || {target, round_idx, score, time_left} !== '0) begin
            errors++; $display("FAIL en_low_run: st=%0d sc=%0d rnd=%0d tl=%0d want 0",
                               state, score, round_idx, time_left);
        end
        en = 1'b1;
        exp_round = 0;
        begin_round();
        guess = exp_tgt;
        press();
        en = 1'b0;
        step();
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0 || state !== 3'd0 || score !== 2'd0) begin
            errors++; $display("FAIL en_low_judge: hit=%b miss=%b st=%0d sc=%0d want 0/0/0/0",
                               hit, miss, state, score);
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        exp_round = 0;
        begin_round();
        guess = exp_tgt;
        press();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || {target, round_idx, score, time_left} !== '0
            || {hit, miss, done, beep} !== 4'b0) begin
            errors++; $display("FAIL async_reset: st=%0d tgt=%0h rnd=%0d flags=%b want all 0",
                               state, target, round_idx, {hit, miss, done, beep});
        end
        step();
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            errors++; $display("FAIL async_reset_pulse: hit=%b miss=%b want 0/0", hit, miss);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_held_start();
        test_hits();
        test_misses();
        test_random_rounds();
        test_timeout();
        test_coincident();
        test_en_low();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
